// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues one-at-a-time reads to instruction memory,
// buffers returned words in a 2-entry FIFO toward decode, and drives the PC register's old_pc.
module if_fetch_unit #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              redirect,
    output logic [ADDR_W-1:0] pc_feedback,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic              id_misaligned,
    input  logic              id_ready
);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              mis_hold_q, mis_hold_d;
    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;

    logic              pop, resp_push, mis_push, push, fetch_ok, issue_state, ack;
    logic [2:0]        occ;
    logic [DATA_W-1:0] push_instr;
    logic [ADDR_W-1:0] push_pc;
    logic              push_mis;

    logic [DATA_W-1:0] ent_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0] ent_pc    [FIFO_DEPTH];
    logic              ent_mis   [FIFO_DEPTH];

    // occ counts the response landing this cycle so the next request can never overfill the FIFO.
    always_comb begin
        pop         = (count_q != 2'd0) && id_ready;
        resp_push   = (state_q == WAIT) && imem_rvalid && !redirect;
        occ         = 3'(count_q) - 3'(pop) + 3'(resp_push);
        issue_state = (state_q == IDLE) || resp_push;
        fetch_ok    = !reset && !redirect && !mis_hold_q && issue_state
                      && (occ < 3'(FIFO_DEPTH));
        imem_req    = fetch_ok && (pc_in[1:0] == 2'b00);
        mis_push    = fetch_ok && (pc_in[1:0] != 2'b00) && (state_q == IDLE);
        ack         = imem_req && imem_ack;
        push        = resp_push || mis_push;
        push_instr  = resp_push ? imem_rdata : '0;
        push_pc     = resp_push ? pend_pc_q : pc_in;
        push_mis    = !resp_push;
    end

    assign imem_addr     = pc_in;
    assign pc_feedback   = ack ? pc_in : pc_in - ADDR_W'(4);
    assign id_valid      = (count_q != 2'd0);
    assign id_instr      = ent_instr[rd_ptr_q];
    assign id_pc         = ent_pc[rd_ptr_q];
    assign id_misaligned = ent_mis[rd_ptr_q];

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = 2'(3'(count_q) + 3'(push) - 3'(pop));
        end
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        logic [DATA_W-1:0] instr_q, instr_d;
        logic [ADDR_W-1:0] pc_q, pc_d;
        logic              mis_q, mis_d;

        always_comb begin
            instr_d = instr_q;
            pc_d    = pc_q;
            mis_d   = mis_q;
            if (push && (wr_ptr_q == 1'(gi))) begin
                instr_d = push_instr;
                pc_d    = push_pc;
                mis_d   = push_mis;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                instr_q <= '0;
                pc_q    <= '0;
                mis_q   <= 1'b0;
            end else begin
                instr_q <= instr_d;
                pc_q    <= pc_d;
                mis_q   <= mis_d;
            end
        end

        assign ent_instr[gi] = instr_q;
        assign ent_pc[gi]    = pc_q;
        assign ent_mis[gi]   = mis_q;
    end

    // A redirect with data arriving the same cycle retires the outstanding read, so nothing is left to drain.
    always_comb begin
        state_d    = state_q;
        pend_pc_d  = ack ? pc_in : pend_pc_q;
        mis_hold_d = mis_hold_q;
        if (redirect)      mis_hold_d = 1'b0;
        else if (mis_push) mis_hold_d = 1'b1;
        unique case (state_q)
            IDLE:    if (ack) state_d = WAIT;
            WAIT: begin
                if (redirect)         state_d = imem_rvalid ? IDLE : DRAIN;
                else if (imem_rvalid) state_d = ack ? WAIT : IDLE;
            end
            DRAIN:   if (imem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pend_pc_q  <= '0;
            mis_hold_q <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_pc_q  <= pend_pc_d;
            mis_hold_q <= mis_hold_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!(push && !pop && count_q == 2'(FIFO_DEPTH)));
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: PC register, memory responder and decode are modelled around the DUT;
// the decode stream is checked against the expected sequential-PC program order.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        redirect;
    logic [31:0] pc_feedback;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_misaligned;
    logic        id_ready;

    always #5 clk = ~clk;

    if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .redirect(redirect),
        .pc_feedback(pc_feedback), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_misaligned(id_misaligned), .id_ready(id_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h8C01_0004;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] r;
        r = $urandom & 32'hFFFF_FFFC;
        case ($urandom_range(7))
            0:       return r | 32'($urandom_range(3, 1));
            1:       return 32'hFFFF_FFF0 + 32'(4 * $urandom_range(3));
            default: return r;
        endcase
    endfunction

    // environment knobs and models
    int          ack_pct, ready_pct, redir_pct, dly_min, dly_max;
    logic        force_redir;
    logic [31:0] force_tgt;
    logic [31:0] pc_q;
    logic        rsp_pend;
    logic [31:0] rsp_addr;
    int          rsp_dly;
    logic [31:0] exp_pc;
    logic        dead;
    int          consumed;
    logic [31:0] first_pc;
    logic        s_req, s_valid, s_mis;
    logic [31:0] s_fb, s_pc, s_instr;

    task automatic env_reset(input logic [31:0] pc0);
        reset = 1'b1; redirect = 1'b0; imem_ack = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; id_ready = 1'b0; pc_in = pc0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_id_mis", 32'(id_misaligned), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_pc_feedback", pc_feedback, pc0 - 32'd4);
        @(posedge clk); #1;
        reset = 1'b0;
        pc_q = pc0; exp_pc = pc0; dead = 1'b0; consumed = 0; first_pc = '0;
        rsp_pend = 1'b0; rsp_dly = 0; force_redir = 1'b0;
    endtask

    task automatic env_cycle();
        logic        redir_now;
        logic [31:0] tgt, pc_next;
        redir_now   = force_redir || ($urandom_range(99) < redir_pct);
        tgt         = force_redir ? force_tgt : rand_target();
        force_redir = 1'b0;
        pc_in       = pc_q;
        redirect    = redir_now;
        id_ready    = ($urandom_range(99) < ready_pct);
        imem_rvalid = rsp_pend && (rsp_dly == 0);
        imem_rdata  = imem_rvalid ? mem_word(rsp_addr) : $urandom;
        imem_ack    = !(rsp_pend && rsp_dly != 0) && ($urandom_range(99) < ack_pct);
        @(negedge clk);
        s_req = imem_req; s_fb = pc_feedback; s_valid = id_valid;
        s_pc = id_pc; s_instr = id_instr; s_mis = id_misaligned;
        if (s_req) begin
            check("req_addr", imem_addr, pc_in);
            check("req_aligned", 32'(pc_in[1:0]), 32'd0);
        end
        if (redirect) check("req_on_redirect", 32'(s_req), 32'd0);
        else check("pc_feedback", s_fb, (s_req && imem_ack) ? pc_in : pc_in - 32'd4);
        if (s_valid && id_ready && !redirect) begin
            if (consumed == 0) first_pc = s_pc;
            consumed++;
            if (dead) begin
                check("extra_entry", 32'(s_valid), 32'd0);
            end else if (exp_pc[1:0] != 2'b00) begin
                check("mis_flag", 32'(s_mis), 32'd1);
                check("mis_pc", s_pc, exp_pc);
                check("mis_instr", s_instr, 32'd0);
                dead = 1'b1;
            end else begin
                check("id_mis", 32'(s_mis), 32'd0);
                check("id_pc", s_pc, exp_pc);
                check("id_instr", s_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (s_req && imem_ack) begin
            rsp_pend = 1'b1; rsp_addr = pc_in; rsp_dly = $urandom_range(dly_max, dly_min);
        end else if (imem_rvalid) begin
            rsp_pend = 1'b0;
        end else if (rsp_pend) begin
            rsp_dly--;
        end
        pc_next = redirect ? tgt : s_fb + 32'd4;
        if (redirect) begin
            exp_pc = tgt; dead = 1'b0;
        end
        @(posedge clk); #1;
        pc_q = pc_next;
    endtask

    task automatic knobs(input int a, input int r, input int d);
        ack_pct = a; ready_pct = r; redir_pct = 0; dly_min = d; dly_max = d;
    endtask

    initial begin
        knobs(100, 100, 0);

        // basic fetch latency
        env_reset(32'h100);
        env_cycle();
        check("t1_req", 32'(s_req), 32'd1);
        check("t1_fb_ack", s_fb, 32'h100);
        env_cycle();
        check("t1_valid_n1", 32'(s_valid), 32'd0);
        env_cycle();
        check("t1_valid_n2", 32'(s_valid), 32'd1);
        check("t1_pc", s_pc, 32'h100);
        check("t1_instr", s_instr, 32'h8C01_0004);
        $display("[TB] basic fetch: id_pc=%08h id_instr=%08h", s_pc, s_instr);

        // backpressure fills exactly two entries
        knobs(100, 0, 0);
        env_reset(32'h200);
        repeat (8) env_cycle();
        check("t2_req_held", 32'(s_req), 32'd0);
        check("t2_pc_held", pc_in, 32'h208);
        check("t2_fb_hold", s_fb, 32'h204);
        check("t2_head", s_pc, 32'h200);
        ready_pct = 100;
        repeat (10) env_cycle();
        check("t2_drained", 32'(consumed >= 3), 32'd1);
        $display("[TB] backpressure: consumed=%0d", consumed);

        // redirect while a read is outstanding
        knobs(100, 100, 3);
        env_reset(32'h300);
        env_cycle();
        force_redir = 1'b1; force_tgt = 32'h8000_0180;
        env_cycle();
        repeat (15) env_cycle();
        check("t3_first_pc", first_pc, 32'h8000_0180);
        $display("[TB] redirect in WAIT: first id_pc=%08h", first_pc);

        // redirect coincides with response while FIFO holds 0x400
        knobs(100, 0, 0);
        env_reset(32'h400);
        repeat (2) env_cycle();
        force_redir = 1'b1; force_tgt = 32'h9000;
        env_cycle();
        check("t4_head_before", s_pc, 32'h400);
        env_cycle();
        check("t4_flushed", 32'(s_valid), 32'd0);
        check("t4_idle_req", 32'(s_req), 32'd1);
        $display("[TB] redirect+rvalid: id_valid=%0d req=%0d", s_valid, s_req);

        // misaligned PC produces one marker and holds
        env_reset(32'h502);
        env_cycle();
        check("t5_no_req", 32'(s_req), 32'd0);
        env_cycle();
        check("t5_valid", 32'(s_valid), 32'd1);
        check("t5_mis", 32'(s_mis), 32'd1);
        check("t5_pc", s_pc, 32'h502);
        check("t5_instr", s_instr, 32'd0);
        repeat (3) env_cycle();
        check("t5_pc_held", pc_in, 32'h502);
        ready_pct = 100;
        env_cycle();
        force_redir = 1'b1; force_tgt = 32'h600;
        env_cycle();
        repeat (6) env_cycle();
        check("t5_resumed", 32'(consumed >= 2), 32'd1);
        $display("[TB] misaligned: consumed=%0d", consumed);

        // reset mid-WAIT, then wrap-around fetch
        knobs(100, 0, 2);
        env_reset(32'h700);
        repeat (5) env_cycle();
        check("t6_one_entry", 32'(s_valid), 32'd1);
        knobs(100, 0, 0);
        env_reset(32'hFFFF_FFFC);
        env_cycle();
        check("t6_req", 32'(s_req), 32'd1);
        check("t6_fb_wrap", s_fb, 32'hFFFF_FFFC);
        env_cycle();
        check("t6_next_pc", pc_in, 32'h0);
        env_cycle();
        check("t6_head", s_pc, 32'hFFFF_FFFC);
        $display("[TB] wrap: head=%08h next pc=%08h", s_pc, pc_in);

        // randomized traffic
        env_reset($urandom & 32'hFFFF_FFFC);
        for (int chunk = 0; chunk < 30; chunk++) begin
            ack_pct   = $urandom_range(100, 20);
            ready_pct = $urandom_range(100, 20);
            redir_pct = $urandom_range(6, 1);
            dly_min   = 0;
            dly_max   = $urandom_range(4);
            repeat (100) env_cycle();
        end
        check("rand_progress", 32'(consumed > 100), 32'd1);
        $display("[TB] random traffic: consumed=%0d", consumed);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that consumes the program counter held in the PC register and drives the `old_pc` feedback that register uses to compute its next value.
- Issues instruction reads to the instruction-memory responder over a req/ack + rvalid interface, at most one read outstanding.
- Buffers returned instructions in a 2-entry FIFO towards decode, using a valid/ready handshake.
- Sits between the PC register, instruction memory and the IF/ID boundary. It discards in-flight fetches on jump, branch or exception redirects.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- DATA_W, 32, instruction width.
- FIFO_DEPTH, 2, decode-side buffer entries (fixed at 2; other values not supported).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clock clk.
- pc_in  input  ADDR_W  current PC from the PC register.
- redirect  input  1  OR of jump/branch/exception this cycle; pc_in carries the target from the next cycle.
- pc_feedback  output  ADDR_W  drives the PC register's `old_pc`: pc_in when advancing, pc_in-4 (mod 2^ADDR_W) when holding.
- imem_req  output  1  read request.
- imem_addr  output  ADDR_W  read address, always equal to pc_in while imem_req=1.
- imem_ack  input  1  responder accepts the request this cycle.
- imem_rvalid  input  1  read data valid, one cycle per accepted request.
- imem_rdata  input  DATA_W  instruction word.
- id_valid  output  1  FIFO head valid towards decode.
- id_instr  output  DATA_W  FIFO head instruction.
- id_pc  output  ADDR_W  PC of FIFO head.
- id_misaligned  output  1  FIFO head is a misaligned-fetch marker; id_instr=0.
- id_ready  input  1  decode consumes head when id_valid and id_ready are both 1.

Behaviour:
- Reset (synchronous):
  - state=IDLE, FIFO empty, outstanding cleared.
  - imem_req=0, id_valid=0, id_instr=0, id_pc=0, id_misaligned=0.
  - pc_feedback=pc_in-4, i.e. hold.
  - The instruction-memory responder shares the same reset; no pre-reset response is ever delivered.
- States:
  - IDLE: no outstanding request.
  - WAIT: request accepted, data pending.
  - DRAIN: redirect occurred while outstanding; the next rvalid is dropped.
- Issue rule: imem_req=1 in IDLE only when all of these hold:
  - redirect=0;
  - (FIFO count minus pop this cycle) < 2;
  - pc_in[1:0]==0.
- Request handshake:
  - imem_addr=pc_in while imem_req=1. imem_req stays high and imem_addr stays stable until imem_ack.
  - On the imem_ack cycle: pc_feedback=pc_in (the PC advances to pc_in+4 next cycle), pc_in is captured as the pending PC, and state goes IDLE→WAIT.
  - On all other cycles: pc_feedback=pc_in-4 (PC holds).
- Misaligned PC:
  - If pc_in[1:0]!=0 in IDLE with FIFO space and redirect=0, no memory request is issued.
  - A marker entry is pushed: id_misaligned=1, id_pc=pc_in, instr=0.
  - pc_feedback holds until redirect.
- Response:
  - In WAIT, imem_rvalid pushes {imem_rdata, pending PC, 0} into the FIFO and state goes to IDLE.
  - A new request may be issued in the same cycle if the issue rule holds.
  - Minimum latency: ack at cycle N, rvalid at N+1, id_valid at N+2 (FIFO output is registered).
- FIFO:
  - Push and pop in the same cycle are both allowed.
  - The issue rule guarantees no push when full. If a push into a full FIFO ever occurs, it is a design error flagged by an assertion.
  - id_* are valid only while id_valid=1.
- Redirect (highest priority):
  - FIFO is flushed in the same cycle; id_valid=0 next cycle; no push.
  - imem_req=0 this cycle. If a request was pending without ack, it is withdrawn.
  - Outstanding states: WAIT→DRAIN. Redirect with imem_rvalid in the same cycle drops the data and goes to IDLE.
  - DRAIN: the next imem_rvalid is dropped and state goes to IDLE. A further redirect while in DRAIN keeps DRAIN.
  - pc_feedback is don't-care during redirect, since the PC register takes the redirect target.
- Reset mid-operation: clears all state immediately regardless of WAIT/DRAIN; a request in flight is lost.
- Wrap-around: PC arithmetic is modulo 2^ADDR_W. pc_in=0xFFFFFFFC advances to 0x00000000; holding at 0 yields pc_feedback=0xFFFFFFFC.

Test Plan:
- Reset, then pc_in=0x100, imem_ack same cycle as req, rvalid next cycle with 0x8C010004 → id_valid=1, id_pc=0x100, id_instr=0x8C010004 two cycles after ack; pc_feedback=0x100 on ack cycle.
- id_ready=0, three fetches from 0x200 → exactly two entries buffered (0x200, 0x204); imem_req stays 0 and pc_feedback=pc_in-4 until id_ready=1; then 0x208 issues.
- Request from 0x300 acked, redirect asserted before rvalid (target 0x80000180) → response for 0x300 never appears on id_*; first id_pc=0x80000180.
- Redirect and imem_rvalid in the same cycle with FIFO holding 0x400 → FIFO flushed, data dropped, id_valid=0 next cycle, state IDLE.
- pc_in=0x502 → no imem_req; id_valid=1, id_misaligned=1, id_pc=0x502, id_instr=0; PC held until redirect.
- Reset asserted in WAIT with 1 FIFO entry → next cycle id_valid=0, imem_req=0, state IDLE; pc_in=0xFFFFFFFC fetch → pc_feedback=0xFFFFFFFC on ack, next PC 0x0.
